dmem_ctrl: RTL and testbench
============================

DMEM_CTRL -- requirements
Module: dmem_ctrl

Interface
REQ-001 Parameter DEPTH, default 64: data memory depth in 32-bit words; power of two, at least 2.
REQ-002 Parameter LATENCY, default 2: wait cycles between request acceptance and memory commit; range 0..15.
REQ-003 Port clk  input  1  single clock; all state changes on its rising edge.
REQ-004 Port reset  input  1  asynchronous, active-low reset.
REQ-005 Port req_valid  input  1  request present.
REQ-006 Port req_ready  output  1  controller can accept a request.
REQ-007 Port req_we  input  1  1 = store, 0 = load.
REQ-008 Port req_size  input  2  00 byte, 01 halfword, 10 word; 11 is illegal.
REQ-009 Port req_unsigned  input  1  zero-extend sub-word loads when 1, sign-extend when 0.
REQ-010 Port req_addr  input  32  byte address.
REQ-011 Port req_wdata  input  32  store data, right-aligned.
REQ-012 Port rsp_valid  output  1  response present.
REQ-013 Port rsp_ready  input  1  consumer accepts the response.
REQ-014 Port rsp_rdata  output  32  load result; 0 for stores and errors.
REQ-015 Port rsp_err  output  1  request was rejected.
REQ-016 Port busy  output  1  1 whenever the FSM is not in IDLE.

Function
REQ-017 The FSM SHALL have three states: IDLE, WAIT and RESP; req_ready = 1 only in IDLE.
REQ-018 A request SHALL be accepted on a rising edge where req_valid & req_ready; addr, we, size, unsigned and wdata are latched, FSM goes to WAIT, and counter = LATENCY.
REQ-019 In WAIT, on each edge: if counter = 0, commit the access and go to RESP; otherwise decrement the counter.
REQ-020 rsp_valid SHALL rise exactly LATENCY+1 edges after the acceptance edge (for LATENCY=2, three edges).
REQ-021 Error conditions: size 11; halfword with addr[0]=1; word with addr[1:0]≠0; or word index addr[31:2] ≥ DEPTH.
REQ-022 An erroring request SHALL take the same latency, perform no write, and respond with rsp_err=1 and rsp_rdata=0.
REQ-023 Store commit: a byte writes wdata[7:0] into lane addr[1:0] only; a halfword writes wdata[15:0] into lanes {addr[1],0} and {addr[1],1} only; a word writes all 4 lanes.
REQ-024 Load commit: extract the addressed lane(s) (lane 0 = bits 7:0); sub-words are extended per the latched unsigned bit; req_unsigned is ignored for words.
REQ-025 In RESP, rsp_valid, rsp_rdata and rsp_err SHALL be held stable until an edge with rsp_ready=1, then the FSM returns to IDLE.
REQ-026 No request SHALL be accepted on the same edge as a response handshake; the earliest next acceptance is the edge after return to IDLE.
REQ-027 rsp_valid = 1 only in RESP; rsp_rdata and rsp_err are 0 outside RESP.
REQ-028 The word index SHALL be addr[clog2(DEPTH)+1:2] after the range check; there is no wrap-around to low addresses.

Reset
REQ-029 While reset=0: FSM=IDLE, counter=0, req_ready=0, rsp_valid=0, rsp_rdata=0, rsp_err=0, busy=0.
REQ-030 req_ready SHALL be 1 from the first cycle after reset deasserts.
REQ-031 Memory contents SHALL NOT be cleared by reset; an access aborted by reset before its commit edge SHALL NOT modify memory.

Verification (DEPTH=64, LATENCY=2)
REQ-032 Word store 0x12345678 @0x54, then word load @0x54 -> rsp_rdata=0x12345678, rsp_err=0, rsp_valid rises 3 edges after each acceptance.
REQ-033 After REQ-032, byte store 0xAB @0x55, then loads:
- signed byte @0x55 -> 0xFFFFFFAB
- unsigned byte @0x55 -> 0x000000AB
- word @0x54 -> 0x1234AB78
REQ-034 Half load @0x57, word store @0x100 (index 64), and size=11 each -> rsp_err=1, rsp_rdata=0; a following word load @0x54 is unchanged.
REQ-035 Hold rsp_ready=0 for 5 cycles in RESP with req_valid=1 -> rsp_* stable, req_ready=0, no second acceptance; accepted on the edge after the handshake.
REQ-036 Drive reset low one cycle after accepting a word store 0xDEADBEEF @0x10, then release -> all outputs at reset values; word load @0x10 returns the prior value.
REQ-037 LATENCY=0 build: a word load SHALL show rsp_valid one edge after acceptance, and back-to-back requests SHALL sustain one transaction every 3 cycles with rsp_ready tied to 1.

Source files
------------

// File: rtl/dmem_ctrl.sv
// Data memory controller: one outstanding request, fixed commit latency,
// byte/half/word loads and stores with alignment and range checking.
module dmem_ctrl #(
    parameter int DEPTH   = 64,
    parameter int LATENCY = 2
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        req_valid,
    output logic        req_ready,
    input  logic        req_we,
    input  logic [1:0]  req_size,
    input  logic        req_unsigned,
    input  logic [31:0] req_addr,
    input  logic [31:0] req_wdata,
    output logic        rsp_valid,
    input  logic        rsp_ready,
    output logic [31:0] rsp_rdata,
    output logic        rsp_err,
    output logic        busy
);

    localparam int AW = $clog2(DEPTH);

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_e;

    state_e      state_q, state_d;
    logic [3:0]  cnt_q, cnt_d;
    logic [31:0] addr_q, addr_d;
    logic [31:0] wdata_q, wdata_d;
    logic [1:0]  size_q, size_d;
    logic        we_q, we_d;
    logic        uns_q, uns_d;
    logic [31:0] rdata_q, rdata_d;
    logic        err_q, err_d;

    logic [31:0] mem [DEPTH];

    logic          misalign;
    logic          oob;
    logic          acc_err;
    logic          commit;
    logic          wr_en;
    logic [AW-1:0] idx;
    logic [31:0]   word;
    logic [7:0]    lb;
    logic [15:0]   lh;
    logic [31:0]   load_val;
    logic [3:0]    be;
    logic [31:0]   wd_al;

    assign misalign = (size_q == 2'b01 && addr_q[0]) ||
                      (size_q == 2'b10 && addr_q[1:0] != 2'b00);
    assign oob      = addr_q[31:2] >= 30'(DEPTH);
    assign acc_err  = (size_q == 2'b11) || misalign || oob;
    assign idx      = addr_q[AW+1:2];
    assign word     = mem[idx];
    assign commit   = reset && state_q == WAIT && cnt_q == 4'd0;
    assign wr_en    = commit && we_q && !acc_err;
    assign wd_al    = wdata_q << {addr_q[1:0], 3'b000};

    always_comb begin
        lb = word[7:0];
        unique case (addr_q[1:0])
            2'd0: lb = word[7:0];
            2'd1: lb = word[15:8];
            2'd2: lb = word[23:16];
            2'd3: lb = word[31:24];
            default: lb = word[7:0];
        endcase
        lh = addr_q[1] ? word[31:16] : word[15:0];
    end

    always_comb begin
        load_val = word;
        be       = 4'b1111;
        unique case (size_q)
            2'b00: begin
                load_val = {{24{!uns_q && lb[7]}}, lb};
                be       = 4'b0001 << addr_q[1:0];
            end
            2'b01: begin
                load_val = {{16{!uns_q && lh[15]}}, lh};
                be       = 4'b0011 << {addr_q[1], 1'b0};
            end
            default: begin
                load_val = word;
                be       = 4'b1111;
            end
        endcase
    end

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        addr_d  = addr_q;
        wdata_d = wdata_q;
        size_d  = size_q;
        we_d    = we_q;
        uns_d   = uns_q;
        rdata_d = rdata_q;
        err_d   = err_q;
        unique case (state_q)
            IDLE: begin
                if (req_valid) begin
                    state_d = WAIT;
                    cnt_d   = 4'(LATENCY);
                    addr_d  = req_addr;
                    wdata_d = req_wdata;
                    size_d  = req_size;
                    we_d    = req_we;
                    uns_d   = req_unsigned;
                end
            end
            WAIT: begin
                if (cnt_q == 4'd0) begin
                    state_d = RESP;
                    err_d   = acc_err;
                    rdata_d = (we_q || acc_err) ? 32'd0 : load_val;
                end else begin
                    cnt_d = cnt_q - 4'd1;
                end
            end
            RESP: begin
                if (rsp_ready) state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_q <= IDLE;
            cnt_q   <= 4'd0;
            addr_q  <= 32'd0;
            wdata_q <= 32'd0;
            size_q  <= 2'b00;
            we_q    <= 1'b0;
            uns_q   <= 1'b0;
            rdata_q <= 32'd0;
            err_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            addr_q  <= addr_d;
            wdata_q <= wdata_d;
            size_q  <= size_d;
            we_q    <= we_d;
            uns_q   <= uns_d;
            rdata_q <= rdata_d;
            err_q   <= err_d;
        end
    end

    // Storage is deliberately outside the reset domain so contents survive reset.
    always_ff @(posedge clk) begin
        if (wr_en) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) mem[idx][8*b +: 8] <= wd_al[8*b +: 8];
            end
        end
    end

    assign req_ready = reset && state_q == IDLE;
    assign rsp_valid = state_q == RESP;
    assign rsp_rdata = rsp_valid ? rdata_q : 32'd0;
    assign rsp_err   = rsp_valid && err_q;
    assign busy      = state_q != IDLE;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Scoreboard bench for dmem_ctrl: byte-array reference model, randomized
// traffic, directed corner cases and a zero-latency instance.
module tb_dmem_ctrl;

    localparam int DEPTH = 64;
    localparam int LAT   = 2;

    logic        clk = 1'b0;
    logic        reset;
    logic        req_valid, req_ready, req_we, req_unsigned;
    logic [1:0]  req_size;
    logic [31:0] req_addr, req_wdata;
    logic        rsp_valid, rsp_ready, rsp_err, busy;
    logic [31:0] rsp_rdata;

    logic        v0, ready0, we0, rv0, err0, busy0;
    logic [31:0] rdata0;

    always #5 clk = ~clk;

    dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(LAT)) u_dut (
        .clk(clk), .reset(reset),
        .req_valid(req_valid), .req_ready(req_ready),
        .req_we(req_we), .req_size(req_size),
        .req_unsigned(req_unsigned), .req_addr(req_addr),
        .req_wdata(req_wdata), .rsp_valid(rsp_valid),
        .rsp_ready(rsp_ready), .rsp_rdata(rsp_rdata),
        .rsp_err(rsp_err), .busy(busy)
    );

    dmem_ctrl #(.DEPTH(DEPTH), .LATENCY(0)) u_dut0 (
        .clk(clk), .reset(reset),
        .req_valid(v0), .req_ready(ready0),
        .req_we(we0), .req_size(2'b10),
        .req_unsigned(1'b0), .req_addr(32'h0),
        .req_wdata(32'h0A0B0C0D), .rsp_valid(rv0),
        .rsp_ready(1'b1), .rsp_rdata(rdata0),
        .rsp_err(err0), .busy(busy0)
    );

    typedef struct {
        logic [31:0] rdata;
        logic        err;
        int          acc;
    } exp_t;

    int   cyc = 0;
    int   n_cmp = 0;
    int   n_bad = 0;
    int   hold_req = 0;
    int   last_hs = 0;
    exp_t exp_q[$];
    logic [7:0] ref_mem [DEPTH*4];

    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string name, input logic [31:0] act,
                       input logic [31:0] req);
        n_cmp++;
        if (act !== req) begin
            n_bad++;
            $display("FAIL %s: got %h required %h (cycle %0d)",
                     name, act, req, cyc);
        end
    endtask

    task automatic fail_now(input string name);
        n_cmp++;
        n_bad++;
        $display("FAIL %s: bound expired (cycle %0d)", name, cyc);
    endtask

    // Reference: memory as a flat byte array, access = n consecutive bytes.
    function automatic exp_t model(input logic we, input logic [1:0] sz,
                                   input logic uns, input logic [31:0] a,
                                   input logic [31:0] wd);
        exp_t e;
        int n;
        logic [31:0] v;
        e.rdata = 32'd0;
        e.acc = 0;
        e.err = (sz == 2'b11) || (sz == 2'b01 && a[0]) ||
                (sz == 2'b10 && a[1:0] != 2'b00) ||
                ((a >> 2) >= 32'(DEPTH));
        if (!e.err) begin
            n = 1 << sz;
            if (we) begin
                for (int i = 0; i < n; i++) ref_mem[a + i] = wd[8*i +: 8];
            end else begin
                v = 32'd0;
                for (int i = 0; i < n; i++)
                    v = v | (32'(ref_mem[a + i]) << (8 * i));
                if (!uns && n < 4 && v[8*n-1])
                    v = v | ~((32'd1 << (8 * n)) - 32'd1);
                e.rdata = v;
            end
        end
        return e;
    endfunction

    // Called at a negedge; returns at the negedge after acceptance.
    task automatic do_req(input logic we, input logic [1:0] sz,
                          input logic uns, input logic [31:0] a,
                          input logic [31:0] wd, output int acc);
        exp_t e;
        int waited = 0;
        acc = -1;
        req_we = we;
        req_size = sz;
        req_unsigned = uns;
        req_addr = a;
        req_wdata = wd;
        req_valid = 1'b1;
        while (!req_ready && waited < 60) begin
            @(negedge clk);
            waited++;
        end
        if (!req_ready) begin
            fail_now("req_accept");
            req_valid = 1'b0;
            return;
        end
        e = model(we, sz, uns, a, wd);
        e.acc = cyc + 1;
        acc = e.acc;
        exp_q.push_back(e);
        @(negedge clk);
        req_valid = 1'b0;
    endtask

    task automatic drain();
        int t = 0;
        while ((exp_q.size() != 0 || rsp_valid) && t < 200) begin
            @(negedge clk);
            t++;
        end
        if (t >= 200) fail_now("drain");
    endtask

    // Monitor and response-side driver.
    initial begin : mon
        exp_t e;
        bit in_resp;
        logic [31:0] hr;
        logic he;
        int hold;
        in_resp = 0;
        hold = 0;
        hr = 32'd0;
        he = 1'b0;
        rsp_ready = 1'b0;
        forever begin
            @(negedge clk);
            if (!reset) begin
                in_resp = 0;
                rsp_ready = 1'b0;
                continue;
            end
            if (rsp_valid) begin
                chk("req_ready_in_resp", {31'd0, req_ready}, 32'd0);
                chk("busy_in_resp", {31'd0, busy}, 32'd1);
                if (!in_resp) begin
                    if (exp_q.size() == 0) begin
                        fail_now("unexpected_rsp");
                    end else begin
                        e = exp_q.pop_front();
                        chk("rdata", rsp_rdata, e.rdata);
                        chk("err", {31'd0, rsp_err}, {31'd0, e.err});
                        chk("latency", 32'(cyc - e.acc), 32'(LAT + 1));
                    end
                    in_resp = 1;
                    hr = rsp_rdata;
                    he = rsp_err;
                    hold = hold_req;
                    hold_req = 0;
                end else begin
                    chk("rdata_stable", rsp_rdata, hr);
                    chk("err_stable", {31'd0, rsp_err}, {31'd0, he});
                end
                if (hold > 0) begin
                    rsp_ready = 1'b0;
                    hold--;
                end else begin
                    rsp_ready = ($urandom_range(0, 2) != 0);
                end
                if (rsp_ready) begin
                    in_resp = 0;
                    last_hs = cyc + 1;
                end
            end else begin
                chk("rdata_idle", rsp_rdata, 32'd0);
                chk("err_idle", {31'd0, rsp_err}, 32'd0);
                rsp_ready = 1'(($urandom_range(0, 1)));
                in_resp = 0;
            end
        end
    end

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin : main
        int acc, acc_a, acc_b;
        logic [1:0] sz;
        logic [31:0] a;
        int acc0[$];
        int n_acc, prev, k;
        reset = 1'b0;
        req_valid = 1'b0;
        req_we = 1'b0;
        req_size = 2'b00;
        req_unsigned = 1'b0;
        req_addr = 32'd0;
        req_wdata = 32'd0;
        v0 = 1'b0;
        we0 = 1'b0;
        repeat (3) @(negedge clk);
        chk("rst_req_ready", {31'd0, req_ready}, 32'd0);
        chk("rst_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("rst_rdata", rsp_rdata, 32'd0);
        chk("rst_err", {31'd0, rsp_err}, 32'd0);
        chk("rst_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("post_rst_ready", {31'd0, req_ready}, 32'd1);

        for (int w = 0; w < DEPTH; w++)
            do_req(1'b1, 2'b10, 1'b0, 32'(w * 4), $urandom, acc);

        do_req(1'b1, 2'b10, 1'b0, 32'h54, 32'h12345678, acc);
        do_req(1'b0, 2'b10, 1'b0, 32'h54, 32'h0, acc);
        do_req(1'b1, 2'b00, 1'b0, 32'h55, 32'h000000AB, acc);
        do_req(1'b0, 2'b00, 1'b0, 32'h55, 32'h0, acc);
        do_req(1'b0, 2'b00, 1'b1, 32'h55, 32'h0, acc);
        do_req(1'b0, 2'b10, 1'b0, 32'h54, 32'h0, acc);
        do_req(1'b0, 2'b01, 1'b0, 32'h57, 32'h0, acc);
        do_req(1'b1, 2'b10, 1'b0, 32'h100, 32'hCAFEF00D, acc);
        do_req(1'b0, 2'b11, 1'b0, 32'h54, 32'h0, acc);
        do_req(1'b0, 2'b10, 1'b0, 32'h54, 32'h0, acc);

        drain();
        hold_req = 5;
        do_req(1'b0, 2'b10, 1'b0, 32'h54, 32'h0, acc_a);
        do_req(1'b0, 2'b00, 1'b1, 32'h55, 32'h0, acc_b);
        chk("accept_after_hs", 32'(acc_b), 32'(last_hs + 1));

        drain();
        req_we = 1'b1;
        req_size = 2'b10;
        req_unsigned = 1'b0;
        req_addr = 32'h10;
        req_wdata = 32'hDEADBEEF;
        req_valid = 1'b1;
        chk("abort_ready", {31'd0, req_ready}, 32'd1);
        @(negedge clk);
        req_valid = 1'b0;
        reset = 1'b0;
        @(negedge clk);
        chk("abort_req_ready", {31'd0, req_ready}, 32'd0);
        chk("abort_rsp_valid", {31'd0, rsp_valid}, 32'd0);
        chk("abort_rdata", rsp_rdata, 32'd0);
        chk("abort_err", {31'd0, rsp_err}, 32'd0);
        chk("abort_busy", {31'd0, busy}, 32'd0);
        reset = 1'b1;
        @(negedge clk);
        chk("abort_post_ready", {31'd0, req_ready}, 32'd1);
        do_req(1'b0, 2'b10, 1'b0, 32'h10, 32'h0, acc);

        repeat (300) begin
            sz = 2'($urandom_range(0, 3));
            a = ($urandom_range(0, 9) == 0) ? $urandom
                : 32'($urandom_range(0, DEPTH * 4 + 7));
            if ($urandom_range(0, 4) != 0) begin
                if (sz == 2'b01) a[0] = 1'b0;
                if (sz == 2'b10) a[1:0] = 2'b00;
            end
            do_req(1'($urandom_range(0, 1)), sz, 1'($urandom_range(0, 1)),
                   a, $urandom, acc);
            if ($urandom_range(0, 3) == 0) @(negedge clk);
        end
        drain();

        n_acc = 0;
        prev = 0;
        k = 0;
        v0 = 1'b1;
        we0 = 1'b1;
        for (int it = 0; it < 15; it++) begin
            if (n_acc >= 1) we0 = 1'b0;
            if (rv0) begin
                if (acc0.size() == 0) begin
                    fail_now("l0_unexpected_rsp");
                end else begin
                    chk("l0_latency", 32'(cyc - acc0.pop_front()), 32'd1);
                    chk("l0_rdata", rdata0, (k == 0) ? 32'd0 : 32'h0A0B0C0D);
                    chk("l0_err", {31'd0, err0}, 32'd0);
                    chk("l0_busy", {31'd0, busy0}, 32'd1);
                end
                k++;
            end
            if (ready0) begin
                acc0.push_back(cyc + 1);
                n_acc++;
                if (n_acc > 1) chk("l0_interval", 32'(cyc + 1 - prev), 32'd3);
                prev = cyc + 1;
            end
            @(negedge clk);
        end
        v0 = 1'b0;
        chk("l0_accepts", 32'(n_acc), 32'd5);
        chk("l0_responses", 32'(k), 32'd5);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
